// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter
//   Round-robin arbiter sharing one NoC ingress channel between CPU_NB
//   valid/ready requesters. One beat is granted per cycle into a one-entry
//   registered output stage, which is tagged with the source index.
//
// Ports
//   clk, rst_n            clock (posedge), async active-low reset
//   req_vld/req_rdy       per-requester handshake (req_rdy combinational)
//   req_data              requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_vld/out_rdy       NoC-side handshake (out_vld registered)
//   out_data, out_src     registered beat and its source index
//   grant_cnt, total_cnt  per-requester / total accepted-beat counters
//
// Build option
//   NOC_RR_ARBITER_STATS_EN : builds the 32-bit counters. Without it the
//   counter ports stay present and are tied to zero.
module noc_rr_arbiter #(
  parameter int CPU_NB     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int IDX_W      = (CPU_NB > 1) ? $clog2(CPU_NB) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CPU_NB-1:0]            req_vld,
  output logic [CPU_NB-1:0]            req_rdy,
  input  logic [CPU_NB*DATA_WIDTH-1:0] req_data,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [IDX_W-1:0]             out_src,
  output logic [CPU_NB*32-1:0]         grant_cnt,
  output logic [31:0]                  total_cnt
);

  logic [CPU_NB-1:0][DATA_WIDTH-1:0] req_data_a;
  assign req_data_a = req_data;

  logic [IDX_W-1:0]      last_q, last_d;
  logic [IDX_W-1:0]      winner;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]      out_src_q, out_src_d;
  logic                  slot_free, accept;

  // First valid requester at or after last+1, wrapping. The offset loop
  // starts at 1 so the previous winner is considered last.
  always_comb begin
    logic found;
    found  = 1'b0;
    winner = last_q;
    for (int k = 1; k <= CPU_NB; k++) begin
      int idx;
      idx = int'(last_q) + k;
      if (idx >= CPU_NB) idx = idx - CPU_NB;
      if (!found && req_vld[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  // rst_n gating keeps ready low while reset is held, so no requester
  // believes a beat was taken by a stage that is being cleared.
  assign slot_free = !out_vld_q || out_rdy;
  assign accept    = rst_n && slot_free && (|req_vld);

  always_comb begin
    req_rdy = '0;
    if (accept) req_rdy[winner] = 1'b1;
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    last_d     = last_q;
    if (accept) begin
      out_vld_d  = 1'b1;
      out_data_d = req_data_a[winner];
      out_src_d  = winner;
      last_d     = winner;
    end else if (out_vld_q && out_rdy) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_src_q  <= '0;
      last_q     <= IDX_W'(CPU_NB - 1);
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      last_q     <= last_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_src  = out_src_q;

`ifdef NOC_RR_ARBITER_STATS_EN
  logic [CPU_NB-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]             total_cnt_q, total_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    total_cnt_d = total_cnt_q;
    if (accept) begin
      grant_cnt_d[winner] = grant_cnt_q[winner] + 32'd1;
      total_cnt_d         = total_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      total_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      total_cnt_q <= total_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign total_cnt = total_cnt_q;
`else
  assign grant_cnt = '0;
  assign total_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Bench for noc_rr_arbiter (CPU_NB=4, 64-bit beats): directed scenarios
// with literal expectations, then randomized traffic with per-source
// sequence numbers checked against a cycle-level reference model.
module tb_noc_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_vld = '0;
  logic [N-1:0]    req_rdy;
  logic [N*DW-1:0] req_data = '0;
  logic            out_vld;
  logic            out_rdy = 1'b0;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_src;
  logic [N*32-1:0] grant_cnt;
  logic [31:0]     total_cnt;

  always #5 clk = ~clk;

  noc_rr_arbiter #(.CPU_NB(N), .DATA_WIDTH(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_data(req_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_src(out_src), .grant_cnt(grant_cnt), .total_cnt(total_cnt)
  );

  int n_chk = 0, n_pass = 0;

  // reference model state
  bit          m_vld;
  logic [63:0] m_data;
  int          m_src, m_last;
  int unsigned m_gcnt[N];
  int unsigned m_total;

  // scoreboard state
  bit          sb_en = 1'b0;
  int unsigned issued[N], exp_next[N];
  int unsigned delivered = 0, accepted_sb = 0;
  bit          last_acc;
  int          last_w;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Rotate the priority order so the requester after 'last' comes first.
  function automatic int pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_vld = 1'b0; m_data = '0; m_src = 0; m_last = N - 1;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    m_total = 0;
  endtask

  // One clock cycle: compare at negedge, advance model at posedge, return
  // #1 after the edge so the caller may drive new inputs.
  task automatic step();
    logic [N-1:0] exp_rdy;
    bit acc;
    int w;
    @(negedge clk);
    w = pick(req_vld, m_last);
    acc = rst_n && (!m_vld || out_rdy) && (req_vld != '0);
    exp_rdy = '0;
    if (acc) exp_rdy[w] = 1'b1;
    check("req_rdy", req_rdy, exp_rdy);
    check("rdy_onehot", $countones(req_rdy) <= 1, 1);
    check("out_vld", out_vld, m_vld);
    check("out_data", out_data, m_data);
    check("out_src", out_src, m_src);
    for (int i = 0; i < N; i++)
`ifdef NOC_RR_ARBITER_STATS_EN
      check("grant_cnt", grant_cnt[i*32 +: 32], m_gcnt[i]);
    check("total_cnt", total_cnt, m_total);
`else
      check("grant_cnt", grant_cnt[i*32 +: 32], 0);
    check("total_cnt", total_cnt, 0);
`endif
    if (sb_en && out_vld && out_rdy) begin
      check("sb_src", out_data[63:56], out_src);
      check("sb_order", out_data[31:0], exp_next[out_src]);
      exp_next[out_src]++;
      delivered++;
    end
    @(posedge clk);
    last_acc = acc; last_w = w;
    if (!rst_n) model_reset();
    else if (acc) begin
      m_vld = 1'b1; m_data = req_data[w*DW +: DW]; m_src = w; m_last = w;
      m_gcnt[w]++; m_total++;
      if (sb_en) accepted_sb++;
    end else if (m_vld && out_rdy) m_vld = 1'b0;
    #1;
  endtask

  int          exp_seq[6] = '{0, 1, 2, 3, 0, 1};
  int unsigned total_base;
  logic [31:0] gsum;

  initial begin
    model_reset();
    // reset held with requests pending: nothing may be granted
    req_vld = 4'hf;
    step(); step();
    check("rst_out_vld", out_vld, 0);
    check("rst_out_data", out_data, 0);
    check("rst_req_rdy", req_rdy, 0);
    rst_n = 1'b1; req_vld = '0; out_rdy = 1'b1;

    // idle: no grants and no pointer movement
    repeat (10) step();
    check("idle_out_vld", out_vld, 0);
    for (int i = 0; i < N; i++)
      req_data[i*DW +: DW] = 64'(i) * 64'h1111_1111_1111_1111;
    req_vld = 4'hf;
    #1 check("first_grant", req_rdy, 4'b0001);

    // all valid: strict rotation with no bubbles
    for (int k = 0; k < 6; k++) begin
      step();
      check("rot_src", out_src, exp_seq[k]);
      check("rot_vld", out_vld, 1);
      check("rot_data", out_data, 64'(exp_seq[k]) * 64'h1111_1111_1111_1111);
    end

    // backpressure on a beat from src 2
    req_vld = 4'b0100;
    req_data[2*DW +: DW] = 64'hdeadbeefdeadbef1;
    step();
    req_vld = 4'hf; out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_vld", out_vld, 1);
      check("bp_data", out_data, 64'hdeadbeefdeadbef1);
      check("bp_src", out_src, 2);
      check("bp_rdy", req_rdy, 0);
    end
    out_rdy = 1'b1;
    #1 check("bp_release_rdy", req_rdy, 4'b1000);
    step();
    check("bp_next_src", out_src, 3);

    // single active requester
    req_vld = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      step();
      check("single_src", out_src, 1);
      check("single_vld", out_vld, 1);
    end
    req_vld = 4'b0011;
    #1 check("after_single_rdy", req_rdy, 4'b0001);
    step();
    check("after_single_src", out_src, 0);

    // async reset with a beat in the output stage
    req_vld = 4'hf; out_rdy = 1'b0;
    step();
    check("pre_rst_vld", out_vld, 1);
    #2 rst_n = 1'b0; model_reset();
    req_vld = 4'b1100;
    #1;
    check("async_rst_vld", out_vld, 0);
    check("async_rst_rdy", req_rdy, 0);
    step();
    rst_n = 1'b1; out_rdy = 1'b1;
    #1 check("post_rst_rdy", req_rdy, 4'b0100);
    step();
    check("post_rst_src", out_src, 2);

    // drain and start randomized traffic
    req_vld = '0;
    step(); step();
    for (int i = 0; i < N; i++) begin issued[i] = 0; exp_next[i] = 0; end
    total_base = m_total;
    sb_en = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_vld[i] && $urandom_range(1) == 1) begin
          req_vld[i] = 1'b1;
          req_data[i*DW +: DW] = {8'(i), 24'h0, issued[i]};
        end
      out_rdy = ($urandom_range(1) == 1);
      step();
      if (last_acc) begin
        issued[last_w]++;
        req_vld[last_w] = 1'b0;
      end
    end
    req_vld = '0; out_rdy = 1'b1;
    step(); step();
    check("sb_no_loss", delivered, accepted_sb);
`ifdef NOC_RR_ARBITER_STATS_EN
    gsum = '0;
    for (int i = 0; i < N; i++) gsum = gsum + grant_cnt[i*32 +: 32];
    check("cnt_sum", gsum, total_cnt);
    check("cnt_vs_sb", total_cnt, total_base + accepted_sb);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/noc_rr_arbiter.md
# noc_rr_arbiter

Round-robin arbiter that shares a single NoC ingress channel between `CPU_NB` cpu→noc valid/ready requesters. It sits between the cpu instances and the NoC. Each cycle it grants at most one requester, registers the granted 64-bit beat in a one-entry output stage, and tags it with the source index. It sustains one beat per cycle while the NoC is ready.

## Interface
Parameters:
- `CPU_NB`, default 4: number of requesters, 1..16.
- `DATA_WIDTH`, default 64: beat width.
- `IDX_W`, default `CPU_NB>1 ? $clog2(CPU_NB) : 1`: width of the source index.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_vld`  in  `CPU_NB`  per-requester valid.
- `req_rdy`  out  `CPU_NB`  per-requester ready (combinational).
- `req_data`  in  `CPU_NB*DATA_WIDTH`  requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `out_vld`  out  1  beat valid toward the NoC (registered).
- `out_rdy`  in  1  NoC ready.
- `out_data`  out  `DATA_WIDTH`  beat (registered).
- `out_src`  out  `IDX_W`  index of the requester that supplied `out_data` (registered).
- `grant_cnt`  out  `CPU_NB*32`  per-requester accepted-beat counters (see Configuration).
- `total_cnt`  out  32  total accepted beats (see Configuration).

## Operation
- Handshake: a transfer happens on a channel when `vld && rdy` at the posedge. A requester must hold `vld` and `data` stable until it sees `rdy`.
- Output stage signals:
  - `slot_free = !out_vld || out_rdy`.
  - `accept = slot_free && |req_vld`.
- Arbitration pointer `last` (IDX_W bits):
  - The winner is the first i with `req_vld[i]`, searching from `(last+1) mod CPU_NB` upward and wrapping.
  - `req_rdy[winner] = accept`. All other `req_rdy` bits are 0.
  - At most one `req_rdy` bit is high in any cycle.
- On `accept`:
  - `out_data <= req_data[winner]`, `out_src <= winner`, `out_vld <= 1`, `last <= winner`.
- When `out_vld && out_rdy && !accept`: `out_vld <= 0`. `out_data` and `out_src` hold their values.
- `last` changes only on accept. Idle cycles do not rotate priority.
- Fairness: with all requesters continuously valid and `out_rdy` high, grants cycle 0,1,…,CPU_NB-1,0,… Worst-case wait is `CPU_NB-1` grants.
- `req_rdy` depends combinationally on `req_vld`, `out_vld`, `out_rdy` and `last`. Requesters must not make `vld` depend on `rdy`.

## Timing
- Reset values: `out_vld=0`, `out_data=0`, `out_src=0`, `last=CPU_NB-1` (requester 0 has first priority), all counters 0.
- `req_rdy` is 0 while `rst_n` is low.
- Latency: a beat accepted at edge N is presented with `out_vld=1` after edge N, so it is visible to the NoC in cycle N+1.
- Throughput: 1 beat/cycle with `out_rdy` held high. Simultaneous drain and accept refills the stage with no bubble.
- Backpressure: `out_vld=1 && out_rdy=0` gives all `req_rdy=0`, and `out_data`/`out_src` stay stable until drained.
- Single active requester: granted every cycle the slot is free, regardless of `last`.
- `CPU_NB=1`: `last` is a constant 0, and the block degrades to a one-entry pipeline register.
- Reset mid-operation: a beat held in the output stage is discarded (`out_vld` drops immediately). Requesters that were not granted keep their `vld`, and arbitration restarts from requester 0.

## Configuration
- Macro `NOC_RR_ARBITER_STATS_EN`.
- Defined:
  - `grant_cnt[i*32 +: 32]` increments on each accept from requester i.
  - `total_cnt` increments on each accept.
  - Both counters are 32-bit, wrap modulo 2^32, are registered, and update at the same edge as the accept.
- Undefined: the counter registers are not built, and `grant_cnt` and `total_cnt` are tied to 0. The ports remain present.

## Test plan
- Reset then idle, `CPU_NB=4`: all `req_vld=0` for 10 cycles → `out_vld=0`, `req_rdy=4'b0000`, `last` unchanged; then `req_vld=4'b1111` with `out_rdy=1` → first grant to 0.
- All 4 valid, `out_rdy=1`, data `i*0x1111_1111_1111_1111` → `out_src` sequence 0,1,2,3,0,1 on consecutive cycles, data matching the source, no bubbles.
- Backpressure: beat from src 2 (`0xdeadbeefdeadbef1`) presented, `out_rdy=0` for 5 cycles → `out_vld=1` and data/src stable, `req_rdy=0`; `out_rdy=1` → the next grant goes to src 3 in the same cycle.
- Only requester 1 valid for 8 cycles, `out_rdy=1` → 8 consecutive beats with `out_src=1`; then requesters 0 and 1 both valid → next grant to 0 (pointer was 1).
- Random `req_vld`/`out_rdy` (50%) for 10000 cycles against a scoreboard → per-source in-order delivery, no loss or duplication, at most one `req_rdy` high per cycle; with `NOC_RR_ARBITER_STATS_EN`, `total_cnt` = sum of `grant_cnt` = scoreboard count.
- Async reset asserted mid-stream with `out_vld=1` → `out_vld` goes to 0 before the next edge; after release, the first grant goes to the lowest valid index.
